// File: rtl/cia_int_ctrl_pkg.sv
// cia_pkg: shared definitions for the CIA interrupt control register block.
//   - ICR bit positions for the five interrupt sources
//   - Set/clear control bit on writes and IR summary bit on reads
//   - Read access FSM state encoding
package cia_pkg;

    localparam int NSRC = 5;

    localparam int ICR_TA   = 0;
    localparam int ICR_TB   = 1;
    localparam int ICR_ALRM = 2;
    localparam int ICR_SP   = 3;
    localparam int ICR_FLG  = 4;

    localparam int ICR_SETCLR = 7;
    localparam int ICR_IR     = 7;

    typedef enum logic {
        IDLE = 1'b0,
        READ = 1'b1
    } state_t;

endpackage

// File: rtl/cia_int_ctrl.sv
// cia_int_ctrl: interrupt control register (ICR) for one CIA.
// Latches one-tick event strobes as pending flags, masks them with a
// set/clear mask register and drives a registered interrupt request.
// A CPU read snapshots the pending flags; only the snapshotted bits are
// cleared when the access ends, so events arriving mid-read stay pending.
//
// Ports:
//   clk      in   system clock
//   reset    in   asynchronous active-high reset
//   clk7_en  in   clock enable, all state advances only when high
//   wr       in   bus write enable (0 = read)
//   icrs     in   ICR register select, high for the whole access
//   data_in  in   [7:0] bus write data (bit 7 = set/clear, 4:0 = mask bits)
//   data_out out  [7:0] bus read data, 0 unless icrs & ~wr
//   ta, tb, alrm, ser, flag  in  event strobes (one clk7_en tick wide)
//   irq      out  interrupt request, active high, registered
//
// State | meaning
// IDLE  | no read access in progress
// READ  | read in progress, r_snap holds the bits being reported
module cia_int_ctrl
    import cia_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clk7_en,
    input  logic       wr,
    input  logic       icrs,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    input  logic       ta,
    input  logic       tb,
    input  logic       alrm,
    input  logic       ser,
    input  logic       flag,
    output logic       irq
);

    state_t            r_state;
    state_t            w_state_next;
    logic [NSRC-1:0]   r_icr;
    logic [NSRC-1:0]   r_imr;
    logic [NSRC-1:0]   r_snap;
    logic              r_irq;

    logic [NSRC-1:0]   w_ev;
    logic [NSRC-1:0]   w_icr_next;
    logic [NSRC-1:0]   w_imr_next;
    logic [NSRC-1:0]   w_snap_next;
    logic [NSRC-1:0]   w_view;
    logic              w_rd;
    logic              w_wr;
    logic              w_rd_enter;
    logic              w_rd_exit;
    logic              w_unused;

    assign w_ev[ICR_TA]   = ta;
    assign w_ev[ICR_TB]   = tb;
    assign w_ev[ICR_ALRM] = alrm;
    assign w_ev[ICR_SP]   = ser;
    assign w_ev[ICR_FLG]  = flag;

    assign w_rd = icrs & ~wr;
    assign w_wr = icrs & wr;

    // Bits 6:5 of a write carry no meaning for this register.
    assign w_unused = ^data_in[6:5];

    assign w_rd_enter = (r_state == IDLE) & w_rd;
    assign w_rd_exit  = (r_state == READ) & ~w_rd;

    // State register and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_icr   <= '0;
            r_imr   <= '0;
            r_snap  <= '0;
            r_irq   <= 1'b0;
        end else if (clk7_en) begin
            r_state <= w_state_next;
            r_icr   <= w_icr_next;
            r_imr   <= w_imr_next;
            r_snap  <= w_snap_next;
            r_irq   <= |(w_icr_next & w_imr_next);
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_rd) w_state_next = READ;
            READ:    if (!w_rd) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Outputs and register next values
    always_comb begin
        w_snap_next = r_snap;
        w_imr_next  = r_imr;
        // New events always set; on read exit they are OR-ed after the
        // clear so a coincident event wins.
        w_icr_next  = r_icr | w_ev;
        if (w_rd_enter)
            w_snap_next = r_icr | w_ev;
        if (w_rd_exit)
            w_icr_next = (r_icr & ~r_snap) | w_ev;
        if (w_wr) begin
            if (data_in[ICR_SETCLR])
                w_imr_next = r_imr | data_in[NSRC-1:0];
            else
                w_imr_next = r_imr & ~data_in[NSRC-1:0];
        end

        // On the entry tick the snapshot is not registered yet, so show
        // the live value to keep reads zero-latency.
        w_view   = (r_state == IDLE) ? (r_icr | w_ev) : r_snap;
        data_out = 8'h00;
        if (w_rd) begin
            data_out[NSRC-1:0] = w_view;
            data_out[ICR_IR]   = |(w_view & r_imr);
        end
    end

    assign irq = r_irq;

endmodule

// File: doc/cia_int_ctrl.md
Name: cia_int_ctrl

Overview:
Interrupt control register (ICR) controller for one CIA. It collects the one-tick event strobes from timer A, timer B, the TOD alarm, the serial port and the FLAG pin, and latches them as pending flags. It masks the flags with a set/clear mask register and drives the CIA interrupt output. Read-to-clear is sequenced with a small access FSM, so an event arriving during a CPU read is never lost.

Parameters:
NSRC, 5, number of interrupt sources (bit 0 timer A, 1 timer B, 2 TOD alarm, 3 serial, 4 FLAG); fixed at 5 for 8520 compatibility.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
clk7_en  in  1  clock enable; all state advances only when high
wr  in  1  bus write enable (0 = read)
icrs  in  1  ICR register select, held high for the whole bus access
data_in  in  8  bus write data
data_out  out  8  bus read data; 0 when not (icrs & ~wr)
ta  in  1  timer A underflow strobe, one clk7_en tick wide
tb  in  1  timer B underflow strobe, one clk7_en tick wide
alrm  in  1  TOD alarm strobe
ser  in  1  serial port byte-complete strobe
flag  in  1  FLAG event strobe, already edge-detected
irq  out  1  interrupt request, active high, registered

Behaviour:
- Reset (async): icr=0, imr=0, snap=0, state=IDLE, irq=0.
- Event vector ev = {flag,ser,alrm,tb,ta}. It is sampled only on clk7_en ticks; any ev bit sets the matching icr bit.
- Write (icrs & wr, each clk7_en tick):
  - data_in[7]=1: imr |= data_in[4:0].
  - data_in[7]=0: imr &= ~data_in[4:0].
  - Bits 6:5 are ignored.
  - A write never clears icr.
- Read FSM, two states:
  - IDLE -> READ on the first tick with icrs & ~wr. On that tick snap <= icr | ev, so events landing on the entry tick are reported.
  - READ -> IDLE on the first tick with icrs low, or with icrs & wr.
  - On exit: icr <= (icr & ~snap) | ev. Only reported bits are cleared; events that arrived during READ stay pending.
- data_out: while icrs & ~wr, data_out = {|(snap & imr), 2'b00, snap[4:0]}. On the entry tick (state still IDLE) the combinational view icr|ev is shown instead, so reads are zero-latency.
- irq is registered: irq <= |(icr_next & imr_next) each tick.
  - Assertion comes one tick after the event tick.
  - Deassertion comes one tick after the clearing read exit or the masking write.
- Simultaneous cases:
  - Event and read exit on the same tick: the set wins.
  - Event and mask-clear on the same tick: icr bit sets, irq stays low.
  - Mask-set on a bit already pending: irq rises next tick.
- When clk7_en is low, all registers hold and the FSM does not advance.
- Reset mid-READ: returns to IDLE immediately with no clear side-effect pending.

Decomposition:
- Shared package cia_pkg holds:
  - ICR bit index localparams: ICR_TA=0, ICR_TB=1, ICR_ALRM=2, ICR_SP=3, ICR_FLG=4.
  - ICR_SETCLR=7, ICR_IR=7.
  - FSM state encoding (IDLE=1'b0, READ=1'b1).
- No sub-module: a flat single module of about 150 lines. FLAG edge detection stays outside, in the port block.

Test Plan:
- Reset, then write 0x82 -> imr=00010. Pulse tb once -> irq=1 exactly one tick later. Read ICR -> 0x82. Deassert icrs -> irq=0 the following tick and icr=0.
- imr=0, pulse ta -> irq stays 0. Read -> 0x01 (bit 7 clear). A second read -> 0x00.
- Write 0x9F, start a read, pulse alrm mid-READ, end the read -> first read returned 0x00. irq asserts from the alarm, and the next read returns 0x84.
- ta pulse on the same tick as a read exit, with imr bit 0 set -> icr[0] stays 1 and irq remains/returns 1. The next read returns 0x81.
- Pending tb with imr=0x02, irq=1, then write 0x02 (clear) -> irq=0 the next tick. Read still returns 0x02 with bit 7=0.
- Assert reset asynchronously (mid-clock) during READ with pending bits -> irq, icr, imr are 0 immediately. After release, a read returns 0x00.
